afifo_wr_arbiter: RTL and testbench

//  Shares the write port of one afifo among NUM_REQ requesters in the write clock domain.

---
 rtl/afifo_wr_arbiter_if.sv | 28 ++
 rtl/afifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_afifo_wr_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_wr_arbiter_if.sv
// rtl/afifo_wr_arbiter_if.sv - requester/afifo write-port bundle shared by the write arbiter
interface afifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_we;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          grant_valid;
  logic [IDW-1:0]                grant_id;

  // Requesters and the afifo status side
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_we, fifo_wdata, grant_valid, grant_id
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_we, fifo_wdata, grant_valid, grant_id
  );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// rtl/afifo_wr_arbiter.sv - round-robin bounded-burst arbiter for one afifo write port (option: AFIFO_ARB_FIXED0_EN)
module afifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input logic clk,
  input logic arst_n,
  afifo_wr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   grant_q;
  logic [IDW-1:0]   rr_last_q;
  logic [BW-1:0]    beat_q;
  logic             grant_valid_q;
  logic [IDW-1:0]   grant_d;
  logic             grant_found;
  logic             in_burst;
  logic             can_write;

  assign in_burst  = (state_q == BURST);
  assign can_write = in_burst & bus.req_valid[grant_q] & ~bus.fifo_full;

  // Next grant: first valid requester after the last one served, wrapping around
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_d     = rr_last_q;
    grant_found = 1'b0;
`ifdef AFIFO_ARB_FIXED0_EN
    if (bus.req_valid[0]) begin
      grant_found = 1'b1;
      grant_d     = '0;
    end
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last_q) + k) % NUM_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_d     = IDW'(idx);
      end
    end
  end

  // Zero-latency write path: only the granted requester sees ready, and never into a full fifo
  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_wdata = '0;
    if (in_burst) begin
      bus.req_ready[grant_q] = ~bus.fifo_full;
      bus.fifo_wdata         = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.fifo_we     = can_write;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_q;

  // Grant FSM: IDLE arbitrates for one cycle, BURST writes until limit, drop of valid, or reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      beat_q        <= '0;
      rr_last_q     <= IDW'(NUM_REQ - 1);
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req_valid) begin
            state_q       <= BURST;
            grant_q       <= grant_d;
            beat_q        <= '0;
            grant_valid_q <= 1'b1;
          end
        end
        BURST: begin
          // A full fifo stalls the burst in place; the grant is kept
          if (!bus.fifo_full) begin
            if (bus.req_valid[grant_q]) begin
              if (beat_q == BW'(MAX_BURST - 1)) begin
                state_q       <= IDLE;
                rr_last_q     <= grant_q;
                beat_q        <= '0;
                grant_valid_q <= 1'b0;
              end else begin
                beat_q <= beat_q + 1'b1;
              end
            end else begin
              state_q       <= IDLE;
              rr_last_q     <= grant_q;
              beat_q        <= '0;
              grant_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// tb/tb_afifo_wr_arbiter.sv - self-checking bench for afifo_wr_arbiter with a queue-level reference model
module tb_afifo_wr_arbiter;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int DEP = 64;

  logic clk;
  logic arst_n;

  afifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  afifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Requester word queues (ring buffers)
  logic [DW-1:0] mem [NR][DEP];
  int head [NR];
  int cnt  [NR];

  // Reference model: who owns the port, beats so far, who was served last
  bit m_burst;
  int m_g;
  int m_beats;
  int m_last;
  int m_writes;

  logic [NR-1:0] cur_v;
  logic          cur_full;
  int            cyc;
  bit            gv_prev;

  logic [DW-1:0] dut_wr[$];
  int            dut_wc[$];
  int            dut_gr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int last);
`ifdef AFIFO_ARB_FIXED0_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic push(input int i, input logic [DW-1:0] w);
    if (cnt[i] < DEP) begin
      mem[i][(head[i] + cnt[i]) % DEP] = w;
      cnt[i]++;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
    end
    dut_wr.delete();
    dut_wc.delete();
    dut_gr.delete();
    m_writes = 0;
  endtask

  task automatic model_reset();
    m_burst = 0;
    m_g     = 0;
    m_beats = 0;
    m_last  = NR - 1;
    gv_prev = 0;
  endtask

  task automatic drive();
    logic [NR*DW-1:0] d;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      cur_v[i] = (cnt[i] > 0);
      if (cnt[i] > 0) d[i*DW +: DW] = mem[i][head[i]];
    end
    bus.req_valid = cur_v;
    bus.req_data  = d;
    bus.fifo_full = cur_full;
  endtask

  // Apply the rules at a clock edge given what the requesters presented
  task automatic model_update();
    int w;
    if (!m_burst) begin
      w = pick(cur_v, m_last);
      if (w >= 0) begin
        m_burst = 1;
        m_g     = w;
        m_beats = 0;
      end
    end else if (!cur_full) begin
      if (cnt[m_g] > 0) begin
        head[m_g] = (head[m_g] + 1) % DEP;
        cnt[m_g]--;
        m_writes++;
        m_beats++;
        if (m_beats == MB) begin
          m_burst = 0;
          m_last  = m_g;
        end
      end else begin
        m_burst = 0;
        m_last  = m_g;
      end
    end
  endtask

  task automatic cycle();
    logic [NR-1:0] er;
    logic          ew;
    logic [DW-1:0] ed;
    drive();
    #2;
    er = '0;
    ew = 1'b0;
    ed = '0;
    if (m_burst) begin
      if (!cur_full) er[m_g] = 1'b1;
      ew = (cnt[m_g] > 0) && !cur_full;
      if (cnt[m_g] > 0) ed = mem[m_g][head[m_g]];
    end
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("fifo_we", 64'(bus.fifo_we), 64'(ew));
    chk("fifo_wdata", 64'(bus.fifo_wdata), 64'(ed));
    chk("grant_valid", 64'(bus.grant_valid), 64'(m_burst));
    chk("grant_id", 64'(bus.grant_id), 64'(m_g));
    if (bus.fifo_we === 1'b1) begin
      dut_wr.push_back(bus.fifo_wdata);
      dut_wc.push_back(cyc);
    end
    if (bus.grant_valid === 1'b1 && !gv_prev) dut_gr.push_back(int'(bus.grant_id));
    gv_prev = (bus.grant_valid === 1'b1);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    arst_n   = 1'b0;
    cur_full = 1'b0;
    drive();
    #1;
    chk("rst_fifo_we", 64'(bus.fifo_we), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_grant_valid", 64'(bus.grant_valid), 64'd0);
    chk("rst_fifo_wdata", 64'(bus.fifo_wdata), 64'd0);
    chk("rst_grant_id", 64'(bus.grant_id), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  task automatic run_until_done(input string tag, input int max);
    int  n;
    bit  pend;
    n    = 0;
    pend = 1;
    while (pend && n < max) begin
      pend = m_burst;
      for (int i = 0; i < NR; i++) if (cnt[i] > 0) pend = 1;
      if (pend) begin
        cycle();
        n++;
      end
    end
    pend = m_burst;
    for (int i = 0; i < NR; i++) if (cnt[i] > 0) pend = 1;
    chk(tag, 64'(pend), 64'd0);
  endtask

  task automatic chk_grants(input string tag, input int ea[5], input int n, input bit exact);
    if (exact) chk({tag, "_count"}, 64'(dut_gr.size()), 64'(n));
    else chk({tag, "_min_count"}, 64'(dut_gr.size() >= n), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i < dut_gr.size()) chk($sformatf("%s_grant%0d", tag, i), 64'(dut_gr[i]), 64'(ea[i]));
    end
  endtask

  initial begin
    int            ea[5];
    logic [DW-1:0] w3[3];
    logic [DW-1:0] w4[4];
    int            n;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    cur_full = 1'b0;
    cur_v    = '0;
    clear_all();

    // 1: single requester, three words, back-to-back writes in order
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w3[i] = $urandom;
      push(0, w3[i]);
    end
    run_until_done("t1_drain", 20);
    chk("t1_nwrites", 64'(dut_wr.size()), 64'd3);
    for (int i = 0; i < 3; i++) if (i < dut_wr.size()) chk($sformatf("t1_word%0d", i), 64'(dut_wr[i]), 64'(w3[i]));
    if (dut_wc.size() == 3) chk("t1_consecutive", 64'(dut_wc[2] - dut_wc[0]), 64'd2);
    ea = '{0, 0, 0, 0, 0};
    chk_grants("t1", ea, 1, 1);

    // 2: everyone busy, bursts capped at MAX_BURST, rotating grants
    clear_all();
    do_reset();
    for (int i = 0; i < NR; i++) for (int j = 0; j < 8; j++) push(i, $urandom);
    run_until_done("t2_drain", 200);
    chk("t2_nwrites", 64'(dut_wr.size()), 64'd32);
    ea = '{0, 1, 2, 3, 0};
    chk_grants("t2", ea, 5, 0);
    chk("t2_ngrants", 64'(dut_gr.size()), 64'd8);

    // 3: fifo full for five cycles in the middle of a burst
    clear_all();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w4[i] = $urandom;
      push(1, w4[i]);
    end
    n = 0;
    while (!(m_burst && m_beats == 2) && n < 10) begin
      cycle();
      n++;
    end
    chk("t3_reach_beat2", 64'(m_burst && m_beats == 2), 64'd1);
    cur_full = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    cur_full = 1'b0;
    run_until_done("t3_drain", 20);
    chk("t3_nwrites", 64'(dut_wr.size()), 64'd4);
    for (int i = 0; i < 4; i++) if (i < dut_wr.size()) chk($sformatf("t3_word%0d", i), 64'(dut_wr[i]), 64'(w4[i]));
    ea = '{1, 0, 0, 0, 0};
    chk_grants("t3", ea, 1, 1);

    // 4: granted requester runs dry after one beat, requester 2 is next
    clear_all();
    do_reset();
    push(0, $urandom);
    push(2, $urandom);
    push(2, $urandom);
    run_until_done("t4_drain", 20);
    ea = '{0, 2, 0, 0, 0};
    chk_grants("t4", ea, 2, 1);

    // 5: asynchronous reset pulse mid-burst
    clear_all();
    do_reset();
    for (int i = 0; i < 4; i++) push(2, $urandom);
    n = 0;
    while (!(m_burst && m_beats == 1) && n < 10) begin
      cycle();
      n++;
    end
    push(1, $urandom);
    drive();
    #2;
    arst_n = 1'b0;
    #1;
    chk("t5_async_we", 64'(bus.fifo_we), 64'd0);
    chk("t5_async_ready", 64'(bus.req_ready), 64'd0);
    chk("t5_async_gv", 64'(bus.grant_valid), 64'd0);
    arst_n = 1'b1;
    model_reset();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    run_until_done("t5_drain", 30);
    ea = '{2, 1, 2, 0, 0};
    chk_grants("t5", ea, 3, 1);
    chk("t5_nwrites", 64'(dut_wr.size()), 64'd5);

    // 6: requester 0 appears while 1..3 are pending
    clear_all();
    do_reset();
    push(1, $urandom);
    push(2, $urandom);
    push(3, $urandom);
    cycle();
    push(0, $urandom);
    run_until_done("t6_drain", 30);
`ifdef AFIFO_ARB_FIXED0_EN
    ea = '{1, 0, 2, 3, 0};
`else
    ea = '{1, 2, 3, 0, 0};
`endif
    chk_grants("t6", ea, 4, 1);

    // Random traffic with random fifo backpressure
    clear_all();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 3) == 0 && cnt[i] < DEP - 4) push(i, $urandom);
      cur_full = ($urandom_range(0, 3) == 0);
      cycle();
    end
    cur_full = 1'b0;
    run_until_done("rand_drain", 2000);
    chk("rand_nwrites", 64'(dut_wr.size()), 64'(m_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
